// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 UART receiver with a receive FIFO behind a valid/ready MMIO slave.
// Optional build macro UART_RX_BLOCKING_EN: an RXDATA read on an empty FIFO stalls
// (uart_ready=0) until a byte arrives instead of returning the empty marker.
`timescale 1ns/1ps

module uart_rx_mmio #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_pin,
   input  logic        bus_valid,
   input  logic        bus_write,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        uart_ready,
   output logic [31:0] mmio_rdata,
   output logic        irq_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int AW           = $clog2(FIFO_DEPTH);

   localparam logic [1:0] REG_RXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

   // Receiver state
   logic             rx_meta, rx_s;
   rx_state_t        state, state_d;
   logic [CNT_W-1:0] clk_cnt, clk_cnt_d;
   logic [2:0]       bit_cnt, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             push_d, ferr_d, push_q, ferr_q;

   // FIFO and status
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [4:0]    count;
   logic          overrun, frame_err;
   logic          empty, full;
   logic [1:0]    addr_sel;
   logic          rd_rx, pop, push_ok, ovr_set, w1c;
   logic          unused_bits;

   assign unused_bits = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[31:4], bus_wdata[1:0]};

   // Two-flop synchroniser for the asynchronous serial line, idling high
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make both flops sample the old values, forming a real 2-stage chain.
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_pin;
         rx_s    <= rx_meta;
      end
   end

   // Receiver state register; push/frame-error strobes are registered one cycle after the stop sample
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shift_q <= '0;
         push_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_d;
         clk_cnt <= clk_cnt_d;
         bit_cnt <= bit_cnt_d;
         shift_q <= shift_d;
         push_q  <= push_d;
         ferr_q  <= ferr_d;
      end
   end

   // Receiver next-state: half-bit start check, then 8 LSB-first data samples and a stop sample
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a variable unassigned (no latches).
      state_d   = state;
      clk_cnt_d = clk_cnt + 1'b1;
      bit_cnt_d = bit_cnt;
      shift_d   = shift_q;
      push_d    = 1'b0;
      ferr_d    = 1'b0;
      case (state)
         S_IDLE: begin
            clk_cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               clk_cnt_d = '0;
               push_d    = rx_s;
               ferr_d    = !rx_s;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign empty    = (count == 5'd0);
   assign full     = (count == 5'(FIFO_DEPTH));
   assign addr_sel = bus_addr[3:2];
   assign rd_rx    = bus_valid && !bus_write && (addr_sel == REG_RXDATA);

`ifdef UART_RX_BLOCKING_EN
   assign uart_ready = bus_valid && !(rd_rx && empty);
`else
   assign uart_ready = bus_valid;
`endif

   assign pop     = rd_rx && uart_ready && !empty;
   // A pop in the same cycle frees the slot the incoming byte needs
   assign push_ok = push_q && (!full || pop);
   assign ovr_set = push_q && full && !pop;
   assign w1c     = bus_valid && bus_write && (addr_sel == REG_STATUS) && uart_ready;

   // FIFO storage write
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
      if (push_ok) mem[wr_ptr] <= shift_q;
   end

   // FIFO pointers, occupancy, sticky flags and interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         irq_o     <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
         // Set has priority over a same-cycle W1C clear
         overrun   <= ovr_set | (overrun   & ~(w1c & bus_wdata[2]));
         frame_err <= ferr_q  | (frame_err & ~(w1c & bus_wdata[3]));
         irq_o     <= !empty;
      end
   end

   // Read mux: combinational from state and address; RXDATA shows the pre-pop head
   always_comb begin
      mmio_rdata = 32'h0;
      case (addr_sel)
         REG_RXDATA: mmio_rdata = {empty, 23'h0, (empty ? 8'h00 : mem[rd_ptr])};
         REG_STATUS: mmio_rdata = {23'h0, count, frame_err, overrun, full, empty};
         default:    mmio_rdata = 32'h0;
      endcase
   end

endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Memory-mapped UART receiver for the RISC-V SoC data bus, the receive-side counterpart of the UART TX path. It deserialises 8N1 frames from the `rx_pin` input and buffers received bytes in a FIFO. It presents data and status to the CPU through the same valid/ready slave handshake the sys_bus uses for other peripherals. Base-address decode is done in sys_bus; this block decodes only `bus_addr[3:2]`.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer division, 434 at defaults).
- `FIFO_DEPTH`, 16: receive FIFO entries. Must be a power of two, from 2 to 16.

Ports:
- `clk`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `rx_pin`  in  1  asynchronous serial input; idles high.
- `bus_valid`  in  1  CPU data access is active and targets this block.
- `bus_write`  in  1  1 = store, 0 = load.
- `bus_addr`  in  32  byte address; only bits [3:2] are decoded.
- `bus_wdata`  in  32  store data.
- `uart_ready`  out  1  access completes this cycle; the CPU stalls while it is low.
- `mmio_rdata`  out  32  load data, combinational from state and address.
- `irq_o`  out  1  registered; high while the FIFO is non-empty.

## Operation
- **Register map** (word offsets):
  - 0x0 RXDATA (read): `{empty, 23'b0, head_byte}`. When empty=1, bits [7:0] read 0.
  - 0x4 STATUS (read): bit0 empty, bit1 full, bit2 overrun, bit3 frame_err, bits[8:4] count, all other bits 0. Write: W1C, where `bus_wdata[2]` clears overrun and `bus_wdata[3]` clears frame_err.
  - 0x8 and 0xC: read 0; writes are ignored. Writes to RXDATA are ignored.
- **Pop**: occurs on the clock edge where `bus_valid && !bus_write && addr==RXDATA && uart_ready && !empty`. Exactly one pop per completed access.
- **Input synchroniser**: `rx_pin` passes through 2 FFs, reset to 1. All logic below uses the synchronised value `rx_s`.
- **Receive state machine**:
  - IDLE: go to START when `rx_s`=0.
  - START: count `CLKS_PER_BIT/2` cycles, then resample. If `rx_s`=1, treat as a false start and return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits LSB-first, each `CLKS_PER_BIT` cycles after the previous sample.
  - STOP: sample once after `CLKS_PER_BIT` more cycles. If `rx_s`=1, push the byte. If `rx_s`=0, discard the byte and set frame_err. Then go to IDLE.
- **Push acceptance**:
  - A push is accepted when `!full`, or when a pop happens in the same cycle; in that case count is unchanged.
  - If the FIFO is full with no concurrent pop, the byte is dropped, overrun is set, and FIFO contents are unchanged.
- **Sticky flags**: overrun and frame_err stay set until W1C or `rst`. If a set event and a W1C clear occur in the same cycle, set wins.
- **Pointers**: wrap modulo FIFO_DEPTH. Count is 5 bits and ranges 0..FIFO_DEPTH.

## Timing
- **Reset values**:
  - `irq_o`=0; FIFO empty; count=0; flags=0; state=IDLE.
  - Synchroniser FFs = 1.
  - `uart_ready` follows its combinational rule. With default config it is 1 whenever `bus_valid`=1.
  - `mmio_rdata` for RXDATA reads 0x8000_0000.
- **Reset during a frame**: the frame is discarded. A subsequent mid-frame low level is handled as a new start, and the false-start check filters it.
- **Receive latency**: count increments exactly `2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1` cycles after the first `clk` edge that samples `rx_pin`=0. `irq_o` rises 1 cycle after that.
- **Read access**: single-cycle (`uart_ready`=1 in the access cycle) unless blocking mode is active (see Configuration). `mmio_rdata` reflects the pre-pop head in that cycle.
- **STATUS after pop or W1C**: a STATUS read in the cycle after the pop or W1C shows the updated count and flags.

## Configuration
- `UART_RX_BLOCKING_EN` defined:
  - An RXDATA read while the FIFO is empty holds `uart_ready`=0, stalling the CPU.
  - The access completes in the first cycle in which empty=0; the byte is returned with bit31=0 and popped.
  - `rst` releases the stall.
- Undefined:
  - An RXDATA read while empty completes immediately, returns 0x8000_0000, and does not pop.
  - `uart_ready` = `bus_valid` for all accesses.

## Test plan
- **Reset**: assert `rst` for 2 cycles -> `irq_o`=0, STATUS=0x0000_0001, RXDATA=0x8000_0000.
- **Single byte**: send 0x55 at 115200 baud, then read RXDATA -> 0x0000_0055. Latency matches the formula exactly. Subsequent STATUS=0x0000_0001 and `irq_o` falls.
- **Overrun**: send 17 bytes 0x00..0x10 with no reads -> STATUS shows count=16, full=1, overrun=1. 16 reads return 0x00..0x0F in order. Writing 0x4 to STATUS clears overrun.
- **Framing error and false start**:
  - Frame 0xA3 with stop bit driven low -> frame_err=1 and count unchanged.
  - A 100-cycle low glitch on `rx_pin` -> no state change.
- **Simultaneous push and pop**: FIFO full, RXDATA read on the stop-sample cycle -> count stays 16, overrun=0, and the new byte lands at the tail.
- **Blocking mode** (`UART_RX_BLOCKING_EN`): RXDATA read while empty -> `uart_ready`=0 until byte 0x7E is pushed, then the access completes with 0x0000_007E and count returns to 0.
